// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID boot checker.
//   state_t       : sequencer states
//   ADDR_ID/TS    : word addresses on the system-ID slave
//   RETRY_W       : width of the retry counter
//   sysid_words_t : captured ID/timestamp payload
package sysid_checker_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RETRY_W = 4;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        LAT_ID = 3'd2,
        RD_TS  = 3'd3,
        LAT_TS = 3'd4,
        CHECK  = 3'd5
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] id;
        logic [DATA_W-1:0] ts;
    } sysid_words_t;

endpackage

// File: rtl/sysid_checker_if.sv
// Minimal Avalon-MM read port between the checker (master) and the
// system-ID slave.
//   avm_address     : 0 = ID word, 1 = timestamp word
//   avm_read        : read strobe, held until accepted
//   avm_waitrequest : slave stall
//   avm_readdata    : slave data
interface sysid_checker_if
    import sysid_checker_pkg::*;
();

    logic              avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );

endinterface

// File: rtl/sysid_rd_pipe.sv
// Read-latency delay line: turns the read-accept strobe into the
// readdata capture strobe LATENCY cycles later.
//   clock, reset : clock and asynchronous active-high reset
//   accept       : read accepted this cycle
//   capture_c    : readdata valid this cycle (same cycle as accept when LATENCY = 0)
module sysid_rd_pipe #(
    parameter int unsigned LATENCY = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic accept,
    output logic capture_c
);

    if (LATENCY == 0) begin : g_wire
        // Zero latency: data is sampled in the acceptance cycle.
        logic unused_clk_rst;
        assign unused_clk_rst = clock ^ reset;
        assign capture_c      = accept;
    end else begin : g_pipe
        logic [LATENCY-1:0] vld_q;

        // Shift the accept strobe through LATENCY stages.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= accept;
                for (int unsigned i = 1; i < LATENCY; i++) begin
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end

        assign capture_c = vld_q[LATENCY-1];
    end

endmodule

// File: rtl/sysid_checker.sv
// Boot-time system-ID checker: reads the ID word (address 0) and the
// timestamp word (address 1), compares both against the expected image,
// retries a bounded number of times on mismatch, then reports pass/fail.
// Optional macro SYSID_CHECK_TIMEOUT_EN adds a per-read waitrequest stall
// timeout; without it reads wait indefinitely and timeout stays 0.
//   clock, reset    : clock, asynchronous active-high reset
//   start           : begins a run, sampled only in IDLE
//   avm             : Avalon-MM read master port
//   id_value        : last captured ID word
//   timestamp_value : last captured timestamp word
//   busy            : high outside IDLE
//   done            : one-cycle pulse at end of a run
//   pass / fail     : sticky result until next accepted start
//   timeout         : sticky, a read stalled too long
//   retry_count     : mismatch retries consumed in the current run
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [DATA_W-1:0] EXPECTED_ID        = 32'd1395937365,
    parameter logic [DATA_W-1:0] EXPECTED_TIMESTAMP = 32'd1539949976,
    parameter int unsigned       READ_LATENCY       = 0,
    parameter int unsigned       MAX_RETRIES        = 3,
    parameter int unsigned       TIMEOUT_CYCLES     = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    sysid_checker_if.master     avm,
    output logic [DATA_W-1:0]   id_value,
    output logic [DATA_W-1:0]   timestamp_value,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic                timeout,
    output logic [RETRY_W-1:0]  retry_count
);

    state_t               state_q, state_d;
    logic                 read_q, read_d;
    logic                 addr_q, addr_d;
    sysid_words_t         words_q, words_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 fail_q, fail_d;
    logic                 timeout_q, timeout_d;

    logic                 accept_c;
    logic                 capture_c;
    logic                 timeout_hit_c;
    logic                 words_match_c;

    assign accept_c      = read_q & ~avm.avm_waitrequest;
    assign words_match_c = (words_q.id == EXPECTED_ID) && (words_q.ts == EXPECTED_TIMESTAMP);

    sysid_rd_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clock     (clock),
        .reset     (reset),
        .accept    (accept_c),
        .capture_c (capture_c)
    );

`ifdef SYSID_CHECK_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_q;
    logic               stalled_c;

    // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle of one read.
    assign stalled_c     = ((state_q == RD_ID) || (state_q == RD_TS)) && avm.avm_waitrequest;
    assign timeout_hit_c = stalled_c && (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));

    // Consecutive-stall counter, cleared on acceptance or leaving a read state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (stalled_c && !timeout_hit_c) begin
            stall_q <= stall_q + STALL_W'(1);
        end else begin
            stall_q <= '0;
        end
    end
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit_c = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            read_q    <= 1'b0;
            addr_q    <= ADDR_ID;
            words_q   <= '0;
            retry_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            read_q    <= read_d;
            addr_q    <= addr_d;
            words_q   <= words_d;
            retry_q   <= retry_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        read_d    = read_q;
        addr_d    = addr_q;
        words_d   = words_q;
        retry_d   = retry_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        done_d    = 1'b0;

        if (timeout_hit_c) begin
            // Stalled read abandoned; consumes no retry.
            state_d   = IDLE;
            read_d    = 1'b0;
            addr_d    = ADDR_ID;
            timeout_d = 1'b1;
            fail_d    = 1'b1;
            done_d    = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = RD_ID;
                        read_d    = 1'b1;
                        addr_d    = ADDR_ID;
                        retry_d   = '0;
                        pass_d    = 1'b0;
                        fail_d    = 1'b0;
                        timeout_d = 1'b0;
                    end
                end

                RD_ID: begin
                    if (accept_c) begin
                        if (capture_c) begin
                            // Zero-latency slave: data already valid, go straight on.
                            words_d.id = avm.avm_readdata;
                            state_d    = RD_TS;
                            addr_d     = ADDR_TS;
                        end else begin
                            state_d = LAT_ID;
                            read_d  = 1'b0;
                        end
                    end
                end

                LAT_ID: begin
                    if (capture_c) begin
                        words_d.id = avm.avm_readdata;
                        state_d    = RD_TS;
                        read_d     = 1'b1;
                        addr_d     = ADDR_TS;
                    end
                end

                RD_TS: begin
                    if (accept_c) begin
                        read_d = 1'b0;
                        if (capture_c) begin
                            words_d.ts = avm.avm_readdata;
                            state_d    = CHECK;
                        end else begin
                            state_d = LAT_TS;
                        end
                    end
                end

                LAT_TS: begin
                    if (capture_c) begin
                        words_d.ts = avm.avm_readdata;
                        state_d    = CHECK;
                    end
                end

                CHECK: begin
                    if (words_match_c) begin
                        pass_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                        addr_d  = ADDR_ID;
                    end else if (retry_q < RETRY_W'(MAX_RETRIES)) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = RD_ID;
                        read_d  = 1'b1;
                        addr_d  = ADDR_ID;
                    end else begin
                        fail_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                        addr_d  = ADDR_ID;
                    end
                end

                default: begin
                    state_d = IDLE;
                    read_d  = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign avm.avm_read    = read_q;
    assign avm.avm_address = addr_q;
    assign id_value        = words_q.id;
    assign timestamp_value = words_q.ts;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign fail            = fail_q;
    assign timeout         = timeout_q;
    assign retry_count     = retry_q;

endmodule
